// File: rtl/usb_tx_timer_pkg.sv
// Shared constants and helpers for the USB TX bit/byte/packet timer.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Provides the default timing constants for a full-speed TX path and a
// counter-width helper that never returns a zero width.
package usb_tx_timer_pkg;

    localparam int USB_DIV_NOM       = 8;
    localparam int USB_BITS_PER_BYTE = 8;
    localparam int USB_ADJ_PERIOD    = 3;
    localparam int USB_LEN_W         = 7;

    // Bits needed to hold values 0..n-1; at least one bit so degenerate
    // counters (n <= 2) still have a legal vector width.
    function automatic int clog2_cnt(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/usb_mod_counter.sv
// Modulo counter: counts 0..i_terminal and wraps, with synchronous clear.
// Latency: count updates one clock after enable; o_at_term is combinational.
// Backpressure: none; the counter advances whenever i_enable is high.
//
// Ports:
//   clk, n_rst  - clock, asynchronous active-low reset
//   i_clear     - synchronous clear to 0 (wins over enable)
//   i_enable    - advance by one (or wrap at terminal)
//   i_terminal  - last value before wrapping; may change cycle by cycle
//   o_count     - current count
//   o_at_term   - count equals i_terminal this cycle
module usb_mod_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             i_clear,
    input  logic             i_enable,
    input  logic [WIDTH-1:0] i_terminal,
    output logic [WIDTH-1:0] o_count,
    output logic             o_at_term
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            if (o_at_term) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + WIDTH'(1);
            end
        end
    end

    assign o_count   = r_count;
    assign o_at_term = (r_count == i_terminal);

endmodule

// File: rtl/usb_tx_bit_timer.sv
// USB TX bit/byte/packet timing generator with periodic one-clock bit stretch.
// Latency: all outputs combinational from registers, timer_en and bit_stuff_en.
// Backpressure: none; timing free-runs while timer_en is high, low clears it.
//
// Ports:
//   clk, n_rst        - system clock, asynchronous active-low reset
//   timer_en          - level enable; low clears every counter on the next edge
//   bit_stuff_en      - current bit period is a stuffed bit (looked at on strobes)
//   pkt_len           - bytes per packet, captured on the enable rising cycle; 0 = unbounded
//   bit_strobe        - pulse at the end of each bit period
//   byte_almost_done  - level while the last counted bit of a byte is in flight
//   byte_done         - pulse on the strobe that completes a byte
//   pkt_done          - pulse on byte_done of the last byte of the packet
//   byte_idx          - index of the byte in progress
module usb_tx_bit_timer
    import usb_tx_timer_pkg::*;
#(
    parameter int DIV_NOM       = USB_DIV_NOM,
    parameter int ADJ_PERIOD    = USB_ADJ_PERIOD,
    parameter int BITS_PER_BYTE = USB_BITS_PER_BYTE,
    parameter int LEN_W         = USB_LEN_W
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             timer_en,
    input  logic             bit_stuff_en,
    input  logic [LEN_W-1:0] pkt_len,
    output logic             bit_strobe,
    output logic             byte_almost_done,
    output logic             byte_done,
    output logic             pkt_done,
    output logic [LEN_W-1:0] byte_idx
);

    // Divider is wide enough for the stretched period DIV_NOM+1.
    localparam int DIV_W = clog2_cnt(DIV_NOM + 2);
    localparam int BIT_W = clog2_cnt(BITS_PER_BYTE);
    localparam int ADJ_W = clog2_cnt((ADJ_PERIOD > 0) ? ADJ_PERIOD : 1);

    localparam logic [DIV_W-1:0] DIV_TERM   = DIV_W'(DIV_NOM - 1);
    localparam logic [BIT_W-1:0] BIT_TERM   = BIT_W'(BITS_PER_BYTE - 1);
    localparam logic [ADJ_W-1:0] ADJ_TERM   = ADJ_W'((ADJ_PERIOD > 0) ? ADJ_PERIOD - 1 : 0);
    localparam logic             STRETCH_ON = (ADJ_PERIOD > 0);

    logic             r_stretch_pending;
    logic             r_en_d;
    logic [LEN_W-1:0] r_len_q;
    logic [LEN_W-1:0] r_byte_idx;

    logic             w_clear;
    logic [DIV_W-1:0] w_div_term;
    logic [DIV_W-1:0] w_div_cnt;
    logic             w_div_at_term;
    logic             w_bit_strobe;
    logic             w_bit_adv;
    logic [BIT_W-1:0] w_bit_cnt;
    logic             w_bit_at_term;
    logic             w_byte_done;
    logic             w_adj_en;
    logic [ADJ_W-1:0] w_adj_cnt;
    logic             w_adj_at_term;
    logic             w_pkt_done;
    logic             w_unused_cnt;

    assign w_clear = ~timer_en;

    // One stretched period of DIV_NOM+1 clocks follows each stretch request.
    assign w_div_term = DIV_TERM + DIV_W'(r_stretch_pending);

    usb_mod_counter #(.WIDTH(DIV_W)) u_div_cnt (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_clear    (w_clear),
        .i_enable   (timer_en),
        .i_terminal (w_div_term),
        .o_count    (w_div_cnt),
        .o_at_term  (w_div_at_term)
    );

    assign w_bit_strobe = timer_en & w_div_at_term;

    // Stuffed bits take a full bit period but are not data bits.
    assign w_bit_adv = w_bit_strobe & ~bit_stuff_en;

    usb_mod_counter #(.WIDTH(BIT_W)) u_bit_cnt (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_clear    (w_clear),
        .i_enable   (w_bit_adv),
        .i_terminal (BIT_TERM),
        .o_count    (w_bit_cnt),
        .o_at_term  (w_bit_at_term)
    );

    assign w_byte_done = w_bit_adv & w_bit_at_term;
    assign w_adj_en    = w_byte_done & STRETCH_ON;

    usb_mod_counter #(.WIDTH(ADJ_W)) u_adj_cnt (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_clear    (w_clear),
        .i_enable   (w_adj_en),
        .i_terminal (ADJ_TERM),
        .o_count    (w_adj_cnt),
        .o_at_term  (w_adj_at_term)
    );

    // Only the terminal flags drive logic; the raw counts are folded here so
    // they are visibly consumed.
    assign w_unused_cnt = ^{w_div_cnt, w_bit_cnt, w_adj_cnt};

    // Setting wins over clearing: the request is raised on the strobe that
    // ends a byte and must survive until the strobe ending the next period.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_stretch_pending <= 1'b0;
        end else if (w_clear) begin
            r_stretch_pending <= 1'b0;
        end else if (w_adj_en && w_adj_at_term) begin
            r_stretch_pending <= 1'b1;
        end else if (w_bit_strobe) begin
            r_stretch_pending <= 1'b0;
        end
    end

    // Packet length is captured only on the enable rising cycle, so host-side
    // changes during a packet cannot shorten or lengthen it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_en_d  <= 1'b0;
            r_len_q <= '0;
        end else begin
            r_en_d <= timer_en;
            if (timer_en && !r_en_d) begin
                r_len_q <= pkt_len;
            end
        end
    end

    assign w_pkt_done = w_byte_done & (r_len_q != '0) &
                        (r_byte_idx == r_len_q - LEN_W'(1));

    // With a zero length the index simply wraps at 2^LEN_W.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_byte_idx <= '0;
        end else if (w_clear) begin
            r_byte_idx <= '0;
        end else if (w_byte_done) begin
            if (w_pkt_done) begin
                r_byte_idx <= '0;
            end else begin
                r_byte_idx <= r_byte_idx + LEN_W'(1);
            end
        end
    end

    assign bit_strobe       = w_bit_strobe;
    assign byte_almost_done = timer_en & w_bit_at_term;
    assign byte_done        = w_byte_done;
    assign pkt_done         = w_pkt_done;
    assign byte_idx         = r_byte_idx;

endmodule

// File: tb/tb_usb_tx_bit_timer.sv
// Directed bench for usb_tx_bit_timer: default instance plus a 4-clock/10-bit,
// non-stretching instance driven from the same inputs.
// Cycle 1 of each run is the first cycle timer_en is sampled high.
module tb_usb_tx_bit_timer;

    localparam int MAXC = 320;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       timer_en;
    logic       bit_stuff_en;
    logic [6:0] pkt_len;

    logic       a_bs, a_bad, a_bd, a_pd;
    logic [6:0] a_idx;
    logic       b_bs, b_bad, b_bd, b_pd;
    logic [6:0] b_idx;

    always #5 clk = ~clk;

    usb_tx_bit_timer u_dut_a (
        .clk              (clk),
        .n_rst            (n_rst),
        .timer_en         (timer_en),
        .bit_stuff_en     (bit_stuff_en),
        .pkt_len          (pkt_len),
        .bit_strobe       (a_bs),
        .byte_almost_done (a_bad),
        .byte_done        (a_bd),
        .pkt_done         (a_pd),
        .byte_idx         (a_idx)
    );

    usb_tx_bit_timer #(
        .DIV_NOM       (4),
        .ADJ_PERIOD    (0),
        .BITS_PER_BYTE (10),
        .LEN_W         (7)
    ) u_dut_b (
        .clk              (clk),
        .n_rst            (n_rst),
        .timer_en         (timer_en),
        .bit_stuff_en     (bit_stuff_en),
        .pkt_len          (pkt_len),
        .bit_strobe       (b_bs),
        .byte_almost_done (b_bad),
        .byte_done        (b_bd),
        .pkt_done         (b_pd),
        .byte_idx         (b_idx)
    );

    int n_vec = 0;
    int n_err = 0;

    logic st_a [MAXC];
    logic al_a [MAXC];
    logic bd_a [MAXC];
    logic pd_a [MAXC];
    int   ix_a [MAXC];
    logic st_b [MAXC];
    logic bd_b [MAXC];

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Cycle of the n-th set entry strictly after cycle 'from'; -1 if none.
    function automatic int nth_set(input logic arr [MAXC], input int from, input int n);
        int k = 0;
        for (int c = from + 1; c < MAXC; c++) begin
            if (arr[c] === 1'b1) begin
                k++;
                if (k == n) return c;
            end
        end
        return -1;
    endfunction

    function automatic int count_set(input logic arr [MAXC], input int lo, input int hi);
        int k = 0;
        for (int c = lo; c <= hi; c++) begin
            if (arr[c] === 1'b1) k++;
        end
        return k;
    endfunction

    // Runs ncyc enabled cycles. stuff_k: 1-based strobe number carrying a
    // stuffed bit; drop_c: cycle with timer_en low; rst_c: cycle with n_rst
    // low; len_c: cycle where pkt_len is rewritten to 2. Zero disables each.
    task automatic run(input int ncyc, input int stuff_k, input int drop_c,
                       input int rst_c, input int len_c);
        int nstb = 0;
        for (int c = 0; c < MAXC; c++) begin
            st_a[c] = 1'b0; al_a[c] = 1'b0; bd_a[c] = 1'b0; pd_a[c] = 1'b0;
            ix_a[c] = 0;    st_b[c] = 1'b0; bd_b[c] = 1'b0;
        end
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            n_rst        = (c != rst_c);
            timer_en     = (c != drop_c);
            if (c == len_c) pkt_len = 7'd2;
            bit_stuff_en = ((nstb + 1) == stuff_k);
            #1;
            st_a[c] = a_bs;
            al_a[c] = a_bad;
            bd_a[c] = a_bd;
            pd_a[c] = a_pd;
            ix_a[c] = int'(a_idx);
            st_b[c] = b_bs;
            bd_b[c] = b_bd;
            if (a_bs === 1'b1) nstb++;
        end
        @(negedge clk);
        timer_en     = 1'b0;
        bit_stuff_en = 1'b0;
        n_rst        = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_rst        = 1'b0;
        timer_en     = 1'b0;
        bit_stuff_en = 1'b0;
        pkt_len      = 7'd0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_bit_strobe", int'(a_bs), 0);
        chk("rst_almost",     int'(a_bad), 0);
        chk("rst_byte_done",  int'(a_bd), 0);
        chk("rst_pkt_done",   int'(a_pd), 0);
        chk("rst_byte_idx",   int'(a_idx), 0);
        chk("rst_b_strobe",   int'(b_bs), 0);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);

        // Free run, no stuffing, unbounded packet; third byte requests a stretch.
        run(260, 0, 0, 0, 0);
        chk("first_strobe",      nth_set(st_a, 0, 1), 8);
        chk("byte1_done",        nth_set(bd_a, 0, 1), 64);
        chk("byte2_done",        nth_set(bd_a, 0, 2), 128);
        chk("byte3_done",        nth_set(bd_a, 0, 3), 192);
        chk("stretched_strobe",  nth_set(st_a, 192, 1), 201);
        chk("byte4_done",        nth_set(bd_a, 0, 4), 257);
        chk("strobe_count",      count_set(st_a, 1, 260), 32);
        chk("no_pkt_done_len0",  count_set(pd_a, 1, 260), 0);
        chk("byte_idx_after4",   ix_a[258], 4);
        chk("b_byte1_done",      nth_set(bd_b, 0, 1), 40);
        chk("b_byte6_done",      nth_set(bd_b, 0, 6), 240);
        chk("b_byte_count",      count_set(bd_b, 1, 260), 6);
        chk("b_strobe_count",    count_set(st_b, 1, 260), 65);

        // Third strobe of byte 0 is stuffed: the byte needs one extra period.
        run(80, 3, 0, 0, 0);
        chk("stuff3_no_early",   int'(bd_a[64]), 0);
        chk("stuff3_almost_60",  int'(al_a[60]), 0);
        chk("stuff3_almost_70",  int'(al_a[70]), 1);
        chk("stuff3_byte_done",  nth_set(bd_a, 0, 1), 72);

        // Stuffed strobe while the last data bit is pending.
        run(80, 8, 0, 0, 0);
        chk("stuff8_strobe_64",  int'(st_a[64]), 1);
        chk("stuff8_no_done_64", int'(bd_a[64]), 0);
        chk("stuff8_almost_66",  int'(al_a[66]), 1);
        chk("stuff8_byte_done",  nth_set(bd_a, 0, 1), 72);

        // Three-byte packet; pkt_len rewritten mid-packet must be ignored.
        pkt_len = 7'd3;
        run(300, 0, 0, 0, 100);
        pkt_len = 7'd0;
        chk("pkt_no_early_done", int'(pd_a[128]), 0);
        chk("pkt_done_cycle",    nth_set(pd_a, 0, 1), 192);
        chk("pkt_byte_done_192", int'(bd_a[192]), 1);
        chk("pkt_idx_last",      ix_a[191], 2);
        chk("pkt_idx_wrap",      ix_a[193], 0);
        chk("pkt_done_count",    count_set(pd_a, 1, 300), 1);

        // timer_en low for the single cycle 100.
        run(170, 0, 100, 0, 0);
        chk("drop_idx_before",   ix_a[99], 1);
        chk("drop_strobe_100",   int'(st_a[100]), 0);
        chk("drop_idx_after",    ix_a[101], 0);
        chk("drop_next_strobe",  nth_set(st_a, 100, 1), 108);
        chk("drop_next_byte",    nth_set(bd_a, 100, 1), 164);

        // n_rst low for cycle 60 while the last bit of byte 0 is in flight.
        run(130, 0, 0, 60, 0);
        chk("rst_almost_59",     int'(al_a[59]), 1);
        chk("rst_almost_60",     int'(al_a[60]), 0);
        chk("rst_strobe_60",     int'(st_a[60]), 0);
        chk("rst_next_strobe",   nth_set(st_a, 60, 1), 68);
        chk("rst_next_byte",     nth_set(bd_a, 60, 1), 124);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/usb_tx_bit_timer.md
# usb_tx_bit_timer

Parametrised bit/byte/packet timing generator for the USB TX path. It divides the system clock into bit strobes and lengthens one bit period every ADJ_PERIOD bytes to absorb clock-ratio error. It counts data bits per byte, excluding stuffed bits, and bytes per packet. It sits between the TX control FSM and the encoder/shift register, and it replaces the fixed 4-bit bit/byte timer.

## Interface
- DIV_NOM, 8: system clocks per nominal bit period, ≥2.
- ADJ_PERIOD, 3: bytes between stretched bits; 0 disables stretching.
- BITS_PER_BYTE, 8: counted data bits per byte, ≥2.
- LEN_W, 7: width of packet length and byte index.
- clk  in  1  system clock.
- n_rst  in  1  reset n_rst, asynchronous, active-low; clock clk.
- timer_en  in  1  level; high = timing runs, low = synchronous clear of all counters.
- bit_stuff_en  in  1  current bit period carries a stuffed bit; sampled only on bit_strobe cycles.
- pkt_len  in  LEN_W  bytes per packet; latched on the timer_en 0→1 cycle; 0 = unbounded.
- bit_strobe  out  1  one-cycle pulse at the end of each bit period.
- byte_almost_done  out  1  level; high while the last counted bit of the byte is in flight.
- byte_done  out  1  one-cycle pulse, coincident with the bit_strobe completing the byte.
- pkt_done  out  1  one-cycle pulse, coincident with byte_done of the last byte.
- byte_idx  out  LEN_W  index of the byte in progress.

## Operation
- div_cnt has width $clog2(DIV_NOM+2). It resets and clears to 0 and increments each enabled cycle.
- The period is DIV_NOM, or DIV_NOM+1 when stretch_pending = 1.
- bit_strobe = timer_en & (div_cnt == period−1). On that cycle div_cnt returns to 0.
- bit_cnt counts 0..BITS_PER_BYTE−1.
  - It increments on bit_strobe & ~bit_stuff_en.
  - It holds on a stuffed strobe.
  - It wraps to 0 after BITS_PER_BYTE−1.
- byte_almost_done = timer_en & (bit_cnt == BITS_PER_BYTE−1).
- byte_done = bit_strobe & ~bit_stuff_en & (bit_cnt == BITS_PER_BYTE−1).
- adj_cnt counts 0..ADJ_PERIOD−1 on byte_done.
  - When byte_done fires with adj_cnt == ADJ_PERIOD−1, stretch_pending sets and adj_cnt wraps.
  - stretch_pending clears on the next bit_strobe, so exactly one period of DIV_NOM+1 clocks follows.
  - With ADJ_PERIOD = 0, stretch_pending never sets.
- byte_idx increments on byte_done.
  - pkt_done = byte_done & (len_q != 0) & (byte_idx == len_q−1). byte_idx then wraps to 0.
  - With len_q = 0, byte_idx wraps naturally at 2^LEN_W and pkt_done never fires.
- When timer_en is low:
  - div_cnt, bit_cnt, adj_cnt, byte_idx and stretch_pending all go to 0 on the next edge.
  - All pulse and level outputs are forced to 0.
- Priority: clear (timer_en low) > wrap > increment.
- A stuffed strobe coinciding with the last bit produces no byte_done. The byte completes on the next unstuffed strobe.
- pkt_len changes while timer_en is high are ignored.

## Timing
- Reset values: bit_strobe, byte_almost_done, byte_done, pkt_done = 0; byte_idx = 0; len_q = 0; stretch_pending = 0.
- The first bit_strobe occurs DIV_NOM cycles after the first cycle timer_en is sampled high (cycle DIV_NOM, counting that cycle as 1).
- Nominal byte length is DIV_NOM·BITS_PER_BYTE clocks, +DIV_NOM per stuffed bit, +1 for a stretched byte.
- All outputs are combinational from registers plus timer_en/bit_stuff_en. Consumers register them.
- Asserting n_rst mid-packet aborts immediately. No pulse appears after release until timer_en has been high for DIV_NOM cycles.

## Structure
- Package usb_tx_timer_pkg holds:
  - default constants USB_DIV_NOM=8, USB_BITS_PER_BYTE=8, USB_ADJ_PERIOD=3, USB_LEN_W=7;
  - function clog2_cnt for counter widths.
- Sub-module usb_mod_counter, parameter WIDTH. Ports: clear, enable, terminal value; outputs count and a terminal-reached flag. It is instantiated three times: div, bit, adj. byte_idx is inline.

## Test plan
- Defaults, timer_en held high, no stuffing, pkt_len=0.
  - bit_strobe every 8 cycles.
  - byte_done at cycles 64, 128, 192.
  - Fourth byte takes 65 cycles: byte_done at 257, first bit period after cycle 192 is 9 clocks.
- bit_stuff_en high on the 3rd strobe of byte 0 → byte_done delayed to cycle 72; bit_cnt holds for that strobe.
- Stuffed strobe while bit_cnt==7 → no byte_done; byte_almost_done stays high; byte_done on the following strobe.
- pkt_len=3 latched at enable → pkt_done coincident with the third byte_done; byte_idx returns to 0. A pkt_len change mid-packet has no effect.
- timer_en dropped for 1 cycle at cycle 100, and separately n_rst pulsed mid-byte → all counters and outputs 0. Next bit_strobe 8 cycles after re-enable.
- ADJ_PERIOD=0, DIV_NOM=4, BITS_PER_BYTE=10 → byte_done every 40 cycles, no stretched periods.
